dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (6-bit byte address, 32-bit data, funct3-encoded access size) between two requesters.
  - Port C is the core load/store unit.
  - Port D is the DMA/debug loader.
- Core has fixed priority. A starvation counter forces a DMA grant after a bounded wait.
- Misaligned accesses are rejected with an error response and never reach memory.
- Sits between the requesters and the DataMem instance. It drives MemRead, MemWrite, addr, data_in and funct3 on the memory, and registers data_out back to the winning requester.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles DMA may request while losing before it is forced to win (1..15).
- CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  core request; held until c_gnt
- c_we  in  1  core write (1) / read (0)
- c_addr  in  6  core byte address
- c_wdata  in  32  core write data
- c_funct3  in  3  core access size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core response valid, one cycle
- c_rdata  out  32  core read data (registered)
- c_err  out  1  core misaligned/illegal access, valid with c_rvalid
- d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata, d_err: same as the core signals, for the DMA port
- m_read  out  1  to DataMem MemRead
- m_write  out  1  to DataMem MemWrite
- m_addr  out  6  to DataMem addr
- m_wdata  out  32  to DataMem data_in
- m_funct3  out  3  to DataMem funct3
- m_rdata  in  32  from DataMem data_out (combinational read)

Behaviour:
- Reset (rst_n low, asynchronous): starve_cnt=0, both rvalid=0, both rdata=0, both err=0. While reset is asserted, gnt and m_read/m_write are forced to 0.
- Arbitration is combinational within the cycle:
  - force_d = (starve_cnt >= STARVE_LIMIT).
  - Winner = D if d_req and (force_d or !c_req); else C if c_req; else none.
  - The winner's gnt is 1, the loser's gnt is 0.
- Mux: the winner's addr, wdata and funct3 drive m_*. m_addr, m_wdata and m_funct3 are 0 when there is no winner.
- Alignment check on the winner:
  - lw (010) requires addr[1:0]=00.
  - lh/lhu (001/101) require addr[0]=0.
  - Byte accesses are always legal.
  - funct3 values 011, 110 and 111 are illegal.
- Legal winner: m_write=we, m_read=!we. Illegal winner: m_read=m_write=0, and gnt is still 1 (the request is consumed).
- Response latency is 1 cycle. At the rising edge where gnt=1, for the winning port only:
  - rvalid <= 1; err <= illegal.
  - rdata <= m_rdata for a legal read, else 0.
- rvalid, err and rdata of a port not granted at that edge: rvalid<=0, err<=0, rdata holds its value.
- A write response carries rdata=0.
- Writes commit to memory at the same edge (DataMem's write timing).
- Starvation counter, at each rising edge:
  - d_req and !d_gnt: starve_cnt increments, saturating at STARVE_LIMIT.
  - d_gnt: starve_cnt <= 0.
  - !d_req: starve_cnt <= 0.
- Requester rules:
  - A requester holds req and its payload stable until gnt.
  - Dropping req before gnt withdraws the request legally; the counter clears if that requester is D.
  - Back-to-back grants to the same port on consecutive cycles are allowed (throughput 1 access/cycle).
- Simultaneous requests with force_d: D wins for one cycle, the counter clears, and C wins the next cycle.
- Reset mid-operation: any pending rvalid is lost. No memory write occurs while rst_n is low.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 encodings F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - DMEM_AW=6 and DMEM_DW=32.
- One sub-module, dmem_align_chk: combinational (funct3, addr) -> illegal. It is reusable by the core's exception logic.

Test Plan:
- Core only: c_req=1, c_we=1, lw, addr 8, wdata DEADBEEF; then a read at addr 8. Required: c_gnt=1 on both cycles, and c_rvalid=1, c_rdata=DEADBEEF one cycle after the read grant.
- Contention: c_req and d_req held high continuously, STARVE_LIMIT=4. Required: C granted for 4 cycles, D granted on the 5th cycle, and the pattern repeats every 5 cycles.
- Misaligned: core lw at addr 10, then lh at addr 13. Required: gnt=1, m_write=m_read=0 on both; next cycle c_err=1, c_rvalid=1, c_rdata=0.
- Byte/half via DMA:
  - Stimulus: with no core request, DMA writes sb EF to addr 12, then performs lb and lbu at addr 12.
  - Required: d_rdata=FFFFFFEF for lb and 000000EF for lbu, each one cycle after grant.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during a granted DMA write to addr 20.
  - Required: gnt, m_write, rvalid and starve_cnt go to 0 immediately; a subsequent read of addr 20 returns the old value.
- Withdraw: d_req pulsed for 2 cycles under core load, then dropped. Required: starve_cnt returns to 0 and no d_rvalid is ever asserted.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: geometry and funct3 access-size encodings.
package dmem_pkg;

  localparam int unsigned DMEM_AW = 6;
  localparam int unsigned DMEM_DW = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational legality check of a data-memory access: size vs. address alignment.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b1;
    case (funct3)
      F3_LB, F3_LBU: illegal = 1'b0;
      F3_LH, F3_LHU: illegal = addr_lo[0];
      F3_LW:         illegal = (addr_lo != 2'b00);
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core priority, DMA starvation
// guard, misaligned accesses answered with an error instead of reaching memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [DMEM_AW-1:0] c_addr,
  input  logic [DMEM_DW-1:0] c_wdata,
  input  logic [2:0]         c_funct3,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [DMEM_DW-1:0] c_rdata,
  output logic               c_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DMEM_AW-1:0] d_addr,
  input  logic [DMEM_DW-1:0] d_wdata,
  input  logic [2:0]         d_funct3,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [DMEM_DW-1:0] d_rdata,
  output logic               d_err,
  output logic               m_read,
  output logic               m_write,
  output logic [DMEM_AW-1:0] m_addr,
  output logic [DMEM_DW-1:0] m_wdata,
  output logic [2:0]         m_funct3,
  input  logic [DMEM_DW-1:0] m_rdata
);

  typedef enum logic [1:0] {WIN_NONE, WIN_C, WIN_D} win_e;

  win_e               win;
  logic [CNT_W-1:0]   starve_cnt;
  logic               force_d;
  logic               sel_we;
  logic               illegal;
  logic [DMEM_DW-1:0] rsp_rdata;

  always_comb begin
    force_d = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    win     = WIN_NONE;
    if (d_req && (force_d || !c_req)) win = WIN_D;
    else if (c_req)                   win = WIN_C;
  end

  always_comb begin
    sel_we   = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_funct3 = '0;
    case (win)
      WIN_C: begin
        sel_we   = c_we;
        m_addr   = c_addr;
        m_wdata  = c_wdata;
        m_funct3 = c_funct3;
      end
      WIN_D: begin
        sel_we   = d_we;
        m_addr   = d_addr;
        m_wdata  = d_wdata;
        m_funct3 = d_funct3;
      end
      default: ;
    endcase
  end

  dmem_align_chk u_align_chk (
    .funct3  (m_funct3),
    .addr_lo (m_addr[1:0]),
    .illegal (illegal)
  );

  // Grants and memory strobes are gated by rst_n so nothing commits during reset.
  always_comb begin
    c_gnt     = rst_n && (win == WIN_C);
    d_gnt     = rst_n && (win == WIN_D);
    m_write   = rst_n && (win != WIN_NONE) && !illegal && sel_we;
    m_read    = rst_n && (win != WIN_NONE) && !illegal && !sel_we;
    rsp_rdata = (!illegal && !sel_we) ? m_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= '0;
    end else if (c_gnt) begin
      c_rvalid <= 1'b1;
      c_err    <= illegal;
      c_rdata  <= rsp_rdata;
    end else begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else if (d_gnt) begin
      d_rvalid <= 1'b1;
      d_err    <= illegal;
      d_rdata  <= rsp_rdata;
    end else begin
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
    end
  end

  // Saturation needs no explicit clamp: at the limit force_d makes D win and clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!d_req || d_gnt) begin
      starve_cnt <= '0;
    end else if (!force_d) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-addressed DataMem model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [5:0]  c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic [2:0]  c_funct3, d_funct3;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        m_read, m_write;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [2:0]  m_funct3;

  logic [7:0]  mem [0:63];
  logic        mem_init;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_funct3(m_funct3), .m_rdata(m_rdata)
  );

  // DataMem model: little-endian, combinational read, write on the clock edge.
  always_comb begin
    logic [5:0] a0, a1, a2, a3;
    a0 = m_addr;
    a1 = m_addr + 6'd1;
    a2 = m_addr + 6'd2;
    a3 = m_addr + 6'd3;
    case (m_funct3)
      3'b000:  m_rdata = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  m_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b100:  m_rdata = {24'd0, mem[a0]};
      3'b101:  m_rdata = {16'd0, mem[a1], mem[a0]};
      default: m_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 64; i++) mem[i] <= 8'(i);
    end else if (m_write) begin
      case (m_funct3[1:0])
        2'b00: mem[m_addr] <= m_wdata[7:0];
        2'b01: begin
          mem[m_addr]         <= m_wdata[7:0];
          mem[m_addr + 6'd1]  <= m_wdata[15:8];
        end
        default: begin
          mem[m_addr]         <= m_wdata[7:0];
          mem[m_addr + 6'd1]  <= m_wdata[15:8];
          mem[m_addr + 6'd2]  <= m_wdata[23:16];
          mem[m_addr + 6'd3]  <= m_wdata[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_funct3 = F3_LW;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = F3_LW;

    // Reset state, with a core request pending that must not be granted
    @(negedge clk); @(negedge clk); #1;
    chk("rst_c_gnt", 32'(c_gnt), 0);
    chk("rst_m_read", 32'(m_read), 0);
    chk("rst_c_rvalid", 32'(c_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_c_err", 32'(c_err), 0);
    chk("rst_cnt", 32'(dut.starve_cnt), 0);
    @(negedge clk);
    c_req = 1'b0; mem_init = 1'b0; rst_n = 1'b1;

    // Core word write then read at addr 8
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_funct3 = F3_LW; c_addr = 6'd8; c_wdata = 32'hDEADBEEF;
    #1;
    chk("t1_wr_gnt", 32'(c_gnt), 1);
    chk("t1_wr_mwrite", 32'(m_write), 1);
    chk("t1_wr_maddr", 32'(m_addr), 8);
    @(negedge clk);
    c_we = 1'b0;
    #1;
    chk("t1_rd_gnt", 32'(c_gnt), 1);
    chk("t1_rd_mread", 32'(m_read), 1);
    chk("t1_wr_rvalid", 32'(c_rvalid), 1);
    chk("t1_wr_rdata", c_rdata, 0);
    @(negedge clk);
    c_req = 1'b0;
    #1;
    chk("t1_rd_rvalid", 32'(c_rvalid), 1);
    chk("t1_rd_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_rd_err", 32'(c_err), 0);

    // Misaligned lw @10, lh @13, then reserved funct3 store
    @(negedge clk);
    chk("t2_idle_rvalid", 32'(c_rvalid), 0);
    c_req = 1'b1; c_we = 1'b0; c_funct3 = F3_LW; c_addr = 6'd10;
    #1;
    chk("t2_lw_gnt", 32'(c_gnt), 1);
    chk("t2_lw_mread", 32'(m_read), 0);
    chk("t2_lw_mwrite", 32'(m_write), 0);
    @(negedge clk);
    c_funct3 = F3_LH; c_addr = 6'd13;
    #1;
    chk("t2_lh_gnt", 32'(c_gnt), 1);
    chk("t2_lh_mread", 32'(m_read), 0);
    chk("t2_lw_err", 32'(c_err), 1);
    chk("t2_lw_rvalid", 32'(c_rvalid), 1);
    chk("t2_lw_rdata", c_rdata, 0);
    @(negedge clk);
    c_we = 1'b1; c_funct3 = 3'b011; c_addr = 6'd0;
    #1;
    chk("t2_f3_mwrite", 32'(m_write), 0);
    chk("t2_lh_err", 32'(c_err), 1);
    chk("t2_lh_rdata", c_rdata, 0);
    @(negedge clk);
    c_req = 1'b0; c_we = 1'b0;
    #1;
    chk("t2_f3_err", 32'(c_err), 1);

    // DMA sb EF @12, then lb and lbu @12
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = F3_LB; d_addr = 6'd12; d_wdata = 32'h000000EF;
    #1;
    chk("t3_sb_gnt", 32'(d_gnt), 1);
    chk("t3_sb_mwrite", 32'(m_write), 1);
    @(negedge clk);
    d_we = 1'b0;
    #1;
    chk("t3_lb_gnt", 32'(d_gnt), 1);
    @(negedge clk);
    d_funct3 = F3_LBU;
    #1;
    chk("t3_lb_rvalid", 32'(d_rvalid), 1);
    chk("t3_lb_rdata", d_rdata, 32'hFFFFFFEF);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("t3_lbu_rdata", d_rdata, 32'h000000EF);

    // Contention: C,C,C,C,D repeating
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_funct3 = F3_LW; c_addr = 6'd0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_LW; d_addr = 6'd4;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk($sformatf("t4_c_gnt_%0d", i), 32'(c_gnt), (i % 5 == 4) ? 0 : 1);
      chk($sformatf("t4_d_gnt_%0d", i), 32'(d_gnt), (i % 5 == 4) ? 1 : 0);
      chk($sformatf("t4_d_rvalid_%0d", i), 32'(d_rvalid), (i == 5) ? 1 : 0);
      if (i == 4) chk("t4_cnt_sat", 32'(dut.starve_cnt), 4);
    end

    // Withdraw: D keeps requesting 2 losing cycles, then drops
    @(negedge clk); #1;
    chk("t5_w0_d_gnt", 32'(d_gnt), 0);
    chk("t5_d_rvalid", 32'(d_rvalid), 1);
    chk("t5_d_rdata", d_rdata, 32'h07060504);
    @(negedge clk); #1;
    chk("t5_w1_d_gnt", 32'(d_gnt), 0);
    chk("t5_w1_d_rvalid", 32'(d_rvalid), 0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("t5_cnt2", 32'(dut.starve_cnt), 2);
    chk("t5_c_gnt", 32'(c_gnt), 1);
    @(negedge clk); #1;
    chk("t5_cnt_clr", 32'(dut.starve_cnt), 0);
    chk("t5_w3_d_rvalid", 32'(d_rvalid), 0);
    c_req = 1'b0;

    // Reset during a granted DMA write to addr 20
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_LW; d_addr = 6'd16;
    #1;
    chk("t6_rd_gnt", 32'(d_gnt), 1);
    @(negedge clk);
    d_we = 1'b1; d_addr = 6'd20; d_wdata = 32'h12345678;
    #1;
    chk("t6_wr_gnt", 32'(d_gnt), 1);
    chk("t6_wr_mwrite", 32'(m_write), 1);
    chk("t6_rvalid_pre", 32'(d_rvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(d_gnt), 0);
    chk("t6_rst_mwrite", 32'(m_write), 0);
    chk("t6_rst_rvalid", 32'(d_rvalid), 0);
    chk("t6_rst_cnt", 32'(dut.starve_cnt), 0);
    @(negedge clk);
    chk("t6_rst_rvalid2", 32'(d_rvalid), 0);
    rst_n = 1'b1; d_we = 1'b0;
    #1;
    chk("t6_read_gnt", 32'(d_gnt), 1);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("t6_read_rvalid", 32'(d_rvalid), 1);
    chk("t6_read_old", d_rdata, 32'h17161514);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
